rpr_stk: RTL and testbench



---
 rtl/rpr_pkg.sv | 46 ++++
 rtl/rpr_lifo.sv | 98 +++++++++
 rtl/rpr_stk.sv | 101 ++++++++++
 tb/tb_rpr_stk.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpr_pkg.sv
// ---------------------------------------------------------------------------
// rpr_pkg
// Shared definitions for the result-flag register (rpr_stk) and its flag
// stack (rpr_lifo).
//   FLAG_Z/N/C/V : bit positions of the flags in the 4-bit flag vector
//   NFLAG        : number of flags (width of one stack entry)
//   cc_e         : branch condition-code encoding seen on the cond input
// ---------------------------------------------------------------------------
package rpr_pkg;

    localparam int NFLAG  = 4;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [2:0] {
        CC_AL = 3'd0,  // always
        CC_EQ = 3'd1,  // Z
        CC_NE = 3'd2,  // !Z
        CC_MI = 3'd3,  // N
        CC_PL = 3'd4,  // !N
        CC_CS = 3'd5,  // C
        CC_VS = 3'd6,  // V
        CC_LT = 3'd7   // N ^ V, signed less-than
    } cc_e;

    // Evaluate one condition code against a flag vector.
    function automatic logic cc_eval(input cc_e cc, input logic [NFLAG-1:0] f);
        logic hit;
        hit = 1'b0;
        case (cc)
            CC_AL:   hit = 1'b1;
            CC_EQ:   hit = f[FLAG_Z];
            CC_NE:   hit = ~f[FLAG_Z];
            CC_MI:   hit = f[FLAG_N];
            CC_PL:   hit = ~f[FLAG_N];
            CC_CS:   hit = f[FLAG_C];
            CC_VS:   hit = f[FLAG_V];
            CC_LT:   hit = f[FLAG_N] ^ f[FLAG_V];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/rpr_lifo.sv
// ---------------------------------------------------------------------------
// rpr_lifo
// Save/restore stack for the flag register.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (resets sp/err only)
//   push, pop     : save wr_data / restore top entry
//   err_clr       : clear the sticky misuse flag
//   wr_data [DW]  : value saved on push (current flags)
//   rd_data [DW]  : top-of-stack entry (entry sp-1), valid when !empty
//   pop_ok        : a legal pop happens this cycle; top takes rd_data
//   sp            : number of stacked entries
//   full, empty   : sp == DEPTH, sp == 0
//   err           : sticky misuse (push full, pop empty, push+pop together)
// ---------------------------------------------------------------------------
module rpr_lifo
    import rpr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = NFLAG,
    localparam int SPW  = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  logic           err_clr,
    input  logic [DW-1:0]  wr_data,
    output logic [DW-1:0]  rd_data,
    output logic           pop_ok,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty,
    output logic           err
);

    logic [DW-1:0]  r_mem [0:(1<<AW)-1];
    logic [SPW-1:0] r_sp;
    logic           r_err;

    logic           w_full;
    logic           w_empty;
    logic           w_do_push;
    logic           w_do_pop;
    logic           w_err_set;
    logic [SPW-1:0] w_sp_m1;
    logic [AW-1:0]  w_wr_addr;
    logic [AW-1:0]  w_rd_addr;

    assign w_full  = (r_sp == SPW'(DEPTH));
    assign w_empty = (r_sp == '0);

    // Simultaneous push and pop is treated as misuse: neither takes effect.
    assign w_do_push = push & ~pop & ~w_full;
    assign w_do_pop  = pop & ~push & ~w_empty;
    assign w_err_set = (push & pop) | (push & w_full) | (pop & w_empty);

    // Write address is sp itself; it never reaches DEPTH while a push is
    // accepted, so the low AW bits are sufficient.
    assign w_sp_m1   = r_sp - SPW'(1);
    assign w_wr_addr = r_sp[AW-1:0];
    assign w_rd_addr = w_sp_m1[AW-1:0];

    // Storage carries no reset; stale entries beyond sp are unreachable.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_sp <= r_sp + SPW'(1);
            end else if (w_do_pop) begin
                r_sp <= w_sp_m1;
            end
            // A new error outranks a coincident clear.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // The restore value must be available in the pop cycle itself.
    assign rd_data = r_mem[w_rd_addr];
    assign pop_ok  = w_do_pop;
    assign sp      = r_sp;
    assign full    = w_full;
    assign empty   = w_empty;
    assign err     = r_err;

endmodule

// File: rtl/rpr_stk.sv
// ---------------------------------------------------------------------------
// rpr_stk
// Result-flag register with masked ALU update, direct load, save/restore
// stack and branch-condition evaluation.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   en, upd_mask    : update flags[i] from the ALU where upd_mask[i]=1
//   res, c_in, v_in : ALU result, carry-out, signed overflow
//   wr, wr_data     : load all four flags directly
//   push, pop       : save / restore flags via the stack
//   err_clr         : clear sticky stack error
//   cond            : condition-code select (cc_e)
//   flags           : {V, C, N, Z}
//   cond_true       : selected condition holds on the registered flags
//   sp, full, empty : stack occupancy / status
//   err             : sticky stack misuse
// Flag register source priority: legal pop > wr > en.
// ---------------------------------------------------------------------------
module rpr_stk
    import rpr_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [W-1:0]     res,
    input  logic             c_in,
    input  logic             v_in,
    input  logic [NFLAG-1:0] upd_mask,
    input  logic             wr,
    input  logic [NFLAG-1:0] wr_data,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    input  logic [2:0]       cond,
    output logic [NFLAG-1:0] flags,
    output logic             cond_true,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty,
    output logic             err
);

    logic [NFLAG-1:0] r_flags;
    logic [NFLAG-1:0] w_derived;
    logic [NFLAG-1:0] w_en_val;
    logic [NFLAG-1:0] w_stk_top;
    logic             w_pop_ok;

    assign w_derived[FLAG_Z] = (res == '0);
    assign w_derived[FLAG_N] = res[W-1];
    assign w_derived[FLAG_C] = c_in;
    assign w_derived[FLAG_V] = v_in;

    // Per-flag merge: masked-off flags keep their current value.
    generate
        for (genvar gi = 0; gi < NFLAG; gi++) begin : g_mask
            assign w_en_val[gi] = upd_mask[gi] ? w_derived[gi] : r_flags[gi];
        end
    endgenerate

    // The stack always saves the pre-edge flags, so wr/en in the same
    // cycle as a push can clear flags on subroutine/interrupt entry.
    rpr_lifo #(
        .DEPTH (DEPTH),
        .DW    (NFLAG)
    ) u_lifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .err_clr (err_clr),
        .wr_data (r_flags),
        .rd_data (w_stk_top),
        .pop_ok  (w_pop_ok),
        .sp      (sp),
        .full    (full),
        .empty   (empty),
        .err     (err)
    );

    // A rejected pop (empty, or together with push) does not block wr/en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_pop_ok) begin
            r_flags <= w_stk_top;
        end else if (wr) begin
            r_flags <= wr_data;
        end else if (en) begin
            r_flags <= w_en_val;
        end
    end

    assign flags     = r_flags;
    assign cond_true = cc_eval(cc_e'(cond), r_flags);

endmodule

// File: tb/tb_rpr_stk.sv
module tb_rpr_stk;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [W-1:0]   res;
    logic           c_in;
    logic           v_in;
    logic [3:0]     upd_mask;
    logic           wr;
    logic [3:0]     wr_data;
    logic           push;
    logic           pop;
    logic           err_clr;
    logic [2:0]     cond;
    logic [3:0]     flags;
    logic           cond_true;
    logic [SPW-1:0] sp;
    logic           full;
    logic           empty;
    logic           err;

    int n_cmp = 0;
    int n_bad = 0;

    rpr_stk #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .res       (res),
        .c_in      (c_in),
        .v_in      (v_in),
        .upd_mask  (upd_mask),
        .wr        (wr),
        .wr_data   (wr_data),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .cond      (cond),
        .flags     (flags),
        .cond_true (cond_true),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       wr;
        logic [3:0] wdat;
        logic [3:0] exp_flags;
    } upd_vec_t;

    typedef struct {
        logic [3:0] f;
        logic [2:0] cc;
        logic       exp;
    } cc_vec_t;

    upd_vec_t upd_tab [0:8];
    cc_vec_t  cc_tab  [0:127];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic idle();
        en = 0; res = '0; c_in = 0; v_in = 0; upd_mask = '0;
        wr = 0; wr_data = '0; push = 0; pop = 0; err_clr = 0;
    endtask

    // Apply the current inputs for one clock edge, then release them.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load(input logic [3:0] v);
        wr = 1; wr_data = v;
        step();
    endtask

    // Hand decode table for the condition codes.
    function automatic logic cc_ref(input logic [3:0] f, input logic [2:0] c);
        logic z, n, cy, v;
        z = f[0]; n = f[1]; cy = f[2]; v = f[3];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return cy;
            3'd6: return v;
            default: return n != v;
        endcase
    endfunction

    initial begin
        // en mask res c v wr wdat -> flags
        upd_tab[0] = '{1, 4'b0011, 8'h00, 1, 0, 0, 4'b0000, 4'b0001};
        upd_tab[1] = '{1, 4'b1111, 8'h80, 1, 1, 0, 4'b0000, 4'b1110};
        upd_tab[2] = '{0, 4'b0000, 8'h00, 0, 0, 1, 4'b1010, 4'b1010};
        upd_tab[3] = '{1, 4'b1000, 8'h00, 0, 0, 0, 4'b0000, 4'b0010};
        upd_tab[4] = '{1, 4'b0001, 8'h01, 1, 1, 0, 4'b0000, 4'b0010};
        upd_tab[5] = '{1, 4'b0101, 8'h00, 1, 1, 0, 4'b0000, 4'b0111};
        upd_tab[6] = '{1, 4'b1111, 8'h00, 0, 0, 1, 4'b0101, 4'b0101};
        upd_tab[7] = '{0, 4'b1111, 8'hFF, 1, 1, 0, 4'b0000, 4'b0101};
        upd_tab[8] = '{1, 4'b1110, 8'h7F, 0, 1, 0, 4'b0000, 4'b1001};
        for (int i = 0; i < 128; i++) begin
            cc_tab[i].f   = 4'(i / 8);
            cc_tab[i].cc  = 3'(i % 8);
            cc_tab[i].exp = cc_ref(cc_tab[i].f, cc_tab[i].cc);
        end

        idle();
        cond  = 3'd0;
        rst_n = 1'b0;
        #2;
        chk("rst_flags", 32'(flags), 0);
        chk("rst_sp", 32'(sp), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cond_al", 32'(cond_true), 1);
        cond = 3'd1;
        #1;
        chk("rst_cond_eq", 32'(cond_true), 0);
        rst_n = 1'b1;
        cond  = 3'd0;
        @(negedge clk);

        // Masked update / direct load table.
        for (int i = 0; i < 9; i++) begin
            en = upd_tab[i].en; upd_mask = upd_tab[i].mask; res = upd_tab[i].res;
            c_in = upd_tab[i].c; v_in = upd_tab[i].v;
            wr = upd_tab[i].wr; wr_data = upd_tab[i].wdat;
            step();
            chk($sformatf("upd[%0d]", i), 32'(flags), 32'(upd_tab[i].exp_flags));
            if (i == 1) begin
                cond = 3'd7;
                #1;
                chk("lt_after_1110", 32'(cond_true), 0);
                cond = 3'd0;
            end
        end

        // Push/pop round trip with entry-time clearing.
        load(4'b0101);
        push = 1; wr = 1; wr_data = 4'b0000;
        step();
        chk("rt_push_flags", 32'(flags), 0);
        chk("rt_push_sp", 32'(sp), 1);
        pop = 1;
        step();
        chk("rt_pop_flags", 32'(flags), 4'b0101);
        chk("rt_pop_sp", 32'(sp), 0);
        chk("rt_pop_empty", 32'(empty), 1);

        // Fill, overflow, clear, drain, underflow.
        for (int k = 1; k <= 5; k++) begin
            push = 1; wr = 1; wr_data = (k == 5) ? 4'b0110 : 4'(k);
            step();
        end
        chk("ov_sp", 32'(sp), 4);
        chk("ov_full", 32'(full), 1);
        chk("ov_err", 32'(err), 1);
        chk("ov_flags", 32'(flags), 4'b0110);
        err_clr = 1;
        step();
        chk("ov_errclr", 32'(err), 0);
        begin
            logic [3:0] exp_pop [0:3];
            exp_pop[0] = 4'b0011; exp_pop[1] = 4'b0010;
            exp_pop[2] = 4'b0001; exp_pop[3] = 4'b0101;
            for (int k = 0; k < 4; k++) begin
                pop = 1;
                step();
                chk($sformatf("drain[%0d]_flags", k), 32'(flags), 32'(exp_pop[k]));
                chk($sformatf("drain[%0d]_sp", k), 32'(sp), 32'(3 - k));
                chk($sformatf("drain[%0d]_err", k), 32'(err), 0);
            end
        end
        chk("drain_empty", 32'(empty), 1);
        pop = 1;
        step();
        chk("un_err", 32'(err), 1);
        chk("un_flags", 32'(flags), 4'b0101);
        chk("un_sp", 32'(sp), 0);
        // Clear coinciding with a new error: error wins.
        pop = 1; err_clr = 1;
        step();
        chk("clr_vs_err", 32'(err), 1);
        err_clr = 1;
        step();
        chk("clr_alone", 32'(err), 0);

        // Pop outranks wr.
        load(4'b1001);
        push = 1;
        step();
        load(4'b0000);
        pop = 1; wr = 1; wr_data = 4'b1111;
        step();
        chk("popwr_flags", 32'(flags), 4'b1001);
        chk("popwr_sp", 32'(sp), 0);
        // Push and pop together: stack unchanged, wr still applies.
        push = 1;
        step();
        push = 1; pop = 1; wr = 1; wr_data = 4'b0110;
        step();
        chk("pp_sp", 32'(sp), 1);
        chk("pp_err", 32'(err), 1);
        chk("pp_flags", 32'(flags), 4'b0110);
        err_clr = 1;
        step();

        // Async reset between edges after three pushes.
        push = 1; step();
        push = 1; step();
        chk("pre_rst_sp", 32'(sp), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_flags", 32'(flags), 0);
        chk("arst_sp", 32'(sp), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_err", 32'(err), 0);
        #1;
        rst_n = 1'b1;
        pop = 1;
        step();
        chk("arst_pop_err", 32'(err), 1);
        chk("arst_pop_sp", 32'(sp), 0);
        err_clr = 1; step();
        load(4'b1100);
        push = 1; step();
        load(4'b0000);
        pop = 1; step();
        chk("arst_repush", 32'(flags), 4'b1100);

        // Condition sweep.
        for (int f = 0; f < 16; f++) begin
            load(4'(f));
            for (int c = 0; c < 8; c++) begin
                cond = cc_tab[f * 8 + c].cc;
                #1;
                chk($sformatf("cc f=%0h c=%0d", cc_tab[f * 8 + c].f, c),
                    32'(cond_true), 32'(cc_tab[f * 8 + c].exp));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
